main_control_fsm: RTL
=====================

# main_control_fsm

Multicycle main control unit for the 8-bit MIPS datapath. Sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the datapath strobes. It produces the `alu_op`/`alu_funct` pair consumed by the ALU control decoder: `alu_op=1` forces ADD, and `alu_op=0` passes `alu_funct` through. It also stalls on a memory ready handshake, halts on illegal opcodes and counts retired instructions.

## Interface
Clock is `clk`; reset is `reset_n`, asynchronous, active-low. There are no parameters; all widths are fixed by the ISA.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `opcode` in 3: IR[15:13]. 000 R-type, 001 ADDI, 010 LW, 011 SW, 100 BEQ, 101 J, 110/111 illegal.
- `funct` in 3: IR[2:0], the R-type ALU function.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `alu_op` out 1: 1 forces ADD; 0 uses `alu_funct`.
- `alu_funct` out 3: ALU function code.
- `alu_src_a` out 1: 0 selects PC; 1 selects register A.
- `alu_src_b` out 2: 00 register B, 01 constant 1, 10 sign-extended immediate.
- `ir_write`, `pc_write`, `mem_read`, `mem_write`, `reg_write` out 1 each: datapath strobes.
- `pc_src` out 2: 00 ALU result, 01 ALUOut register, 10 jump target.
- `reg_dst` out 1: 1 selects rd; 0 selects rt.
- `mem_to_reg` out 1: 1 selects the memory data register; 0 selects ALUOut.
- `halted` out 1: high in the HALT state.
- `retired_count` out 8: count of completed instructions; wraps.

## Operation
States are FETCH, DECODE, EXEC_R, EXEC_I, MEM, WB, BRANCH, JUMP and HALT. Outputs are decoded from the state plus `mem_ready`/`zero`. Any output not listed for a state is 0.
- **FETCH**: `mem_read=1`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=1`.
  - Holds while `mem_ready=0`.
  - When `mem_ready=1`: `ir_write=1`, `pc_write=1`, `pc_src=00`, then go to DECODE.
- **DECODE**: `alu_src_a=0`, `alu_src_b=10`, `alu_op=1`; this precomputes the branch target into ALUOut. Next state by opcode:
  - 000 → EXEC_R
  - 001/010/011 → EXEC_I
  - 100 → BRANCH
  - 101 → JUMP
  - 110/111 → HALT
- **EXEC_R**: `alu_src_a=1`, `alu_src_b=00`, `alu_op=0`, `alu_funct=funct`, then go to WB.
- **EXEC_I**: `alu_src_a=1`, `alu_src_b=10`, `alu_op=1`. ADDI → WB; LW/SW → MEM.
- **MEM**: LW asserts `mem_read=1`; SW asserts `mem_write=1`. Holds while `mem_ready=0`. On `mem_ready=1`, LW → WB and SW → FETCH (retire).
- **WB**: `reg_write=1`. `reg_dst=1` for R-type only. `mem_to_reg=1` for LW only. Then go to FETCH (retire).
- **BRANCH**: `alu_src_a=1`, `alu_src_b=00`, `alu_op=0`, `alu_funct=010` (SUB), `pc_src=01`, `pc_write=zero`. Then go to FETCH (retire).
- **JUMP**: `pc_write=1`, `pc_src=10`. Then go to FETCH (retire).
- **HALT**: `halted=1`, all strobes 0. The FSM stays in HALT until reset. HALT is not a retirement.
- **Retire counting**: `retired_count` increments by 1 on each transition into FETCH from MEM, WB, BRANCH or JUMP. It wraps from 255 to 0.
- **Operand stability**: `opcode` and `funct` are stable from DECODE onward, because IR is written only in FETCH.

## Timing
- **Reset**: while `reset_n=0`, state=FETCH and `retired_count=0`. Every output, including `mem_read`, is forced to 0 combinationally.
- **After reset release**: FETCH strobes appear in the first cycle.
- **Reset mid-instruction**: abandons the instruction immediately. No strobe glitches high and the count is not incremented.
- **Cycles per instruction** with `mem_ready` tied high:
  - R-type and ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
- **Wait states**: each cycle with `mem_ready=0` in FETCH or MEM adds exactly 1 cycle. Strobes hold steady during a wait. `ir_write`/`pc_write` assert only in the `mem_ready` cycle.
- **Ignored `mem_ready`**: `mem_ready` outside FETCH/MEM has no effect.
- **Output paths**: outputs are combinational from registered state and have no register stage. `pc_write` in BRANCH is combinational from `zero`.

## Structure
- The shared package `mips_pkg` holds:
  - the state enum
  - the opcode constants OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - the ALU codes ALU_ADD=3'b001 and ALU_SUB=3'b010
  - the `alu_src_b`/`pc_src` encodings
- One sub-module, `control_output_decode`: a purely combinational mapping from (state, opcode, funct, zero, mem_ready) to strobes.
- The state register, next-state logic and retire counter stay in `main_control_fsm`.

## Test plan
- **R-type**: opcode=000, funct=010, `mem_ready`=1.
  - Required: FETCH (`ir_write`, `pc_write`), DECODE, EXEC_R with `alu_op=0` and `alu_funct=010`, WB with `reg_write=1` and `reg_dst=1`.
  - `retired_count` goes 0→1 after 4 cycles.
- **LW with waits**: opcode=010, `mem_ready` low for 2 cycles in MEM.
  - Required: `mem_read` held for 3 MEM cycles, then WB with `mem_to_reg=1`. Total 7 cycles.
- **BEQ**: opcode=100.
  - With `zero=1`: `pc_write=1` and `pc_src=01` in BRANCH.
  - With `zero=0`: `pc_write=0`.
  - Both cases take 3 cycles and increment the count.
- **Illegal opcode**: opcode=111.
  - Required: DECODE→HALT, `halted=1`, all strobes 0 for 20 cycles, count unchanged.
  - Asserting `reset_n=0` returns to FETCH with `halted=0`.
- **Counter wrap**: 256 back-to-back J instructions.
  - Required: `retired_count` reads 255, then 0.
- **Reset mid-MEM**: drop `reset_n` during SW MEM.
  - Required: `mem_write` falls in the same cycle, and `retired_count=0`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcodes, ALU function codes and datapath mux selects.
package mips_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned FUNCT_W  = 3;
    localparam int unsigned COUNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = 3'b000;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
    localparam logic [OP_W-1:0] OP_LW   = 3'b010;
    localparam logic [OP_W-1:0] OP_SW   = 3'b011;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b100;
    localparam logic [OP_W-1:0] OP_J    = 3'b101;

    localparam logic [FUNCT_W-1:0] ALU_ADD = 3'b001;
    localparam logic [FUNCT_W-1:0] ALU_SUB = 3'b010;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_output_decode.sv
// Combinational strobe decode: maps the current control state plus the
// instruction fields and handshake inputs onto the datapath controls.
module control_output_decode
    import mips_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               alu_op,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ir_write,
    output logic               pc_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         pc_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               halted
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        alu_op     = 1'b0;
        alu_funct  = '0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_ONE;
                alu_op    = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            // Branch target is precomputed into ALUOut here.
            S_DECODE: begin
                alu_src_b = SRC_B_IMM;
                alu_op    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_funct = funct;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = 1'b1;
            end
            S_MEM: begin
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_R);
                mem_to_reg = (opcode == OP_LW);
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_funct = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, halts on illegal opcodes and counts retirements.
module main_control_fsm
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               alu_op,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ir_write,
    output logic               pc_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         pc_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               halted,
    output logic [COUNT_W-1:0] retired_count
);

    localparam int unsigned CTRL_W = 17;

    state_t state, next_state;
    logic   retire;

    logic               alu_op_d, alu_src_a_d, ir_write_d, pc_write_d;
    logic               mem_read_d, mem_write_d, reg_write_d;
    logic               reg_dst_d, mem_to_reg_d, halted_d;
    logic [FUNCT_W-1:0] alu_funct_d;
    logic [1:0]         alu_src_b_d, pc_src_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_FETCH;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                retired_count <= retired_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:                   next_state = S_EXEC_R;
                    OP_ADDI, OP_LW, OP_SW:  next_state = S_EXEC_I;
                    OP_BEQ:                 next_state = S_BRANCH;
                    OP_J:                   next_state = S_JUMP;
                    default:                next_state = S_HALT;
                endcase
            end
            S_EXEC_R: next_state = S_WB;
            S_EXEC_I: next_state = (opcode == OP_ADDI) ? S_WB : S_MEM;
            S_MEM: begin
                if (mem_ready) next_state = (opcode == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Only completed instructions return to FETCH; HALT never does.
    assign retire = (next_state == S_FETCH) &&
                    ((state == S_MEM) || (state == S_WB) ||
                     (state == S_BRANCH) || (state == S_JUMP));

    control_output_decode u_decode (
        .state      (STATE_W'(state)),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op_d),
        .alu_funct  (alu_funct_d),
        .alu_src_a  (alu_src_a_d),
        .alu_src_b  (alu_src_b_d),
        .ir_write   (ir_write_d),
        .pc_write   (pc_write_d),
        .mem_read   (mem_read_d),
        .mem_write  (mem_write_d),
        .reg_write  (reg_write_d),
        .pc_src     (pc_src_d),
        .reg_dst    (reg_dst_d),
        .mem_to_reg (mem_to_reg_d),
        .halted     (halted_d)
    );

    // Reset masks every control output without waiting for a clock edge.
    assign {alu_op, alu_funct, alu_src_a, alu_src_b, ir_write, pc_write,
            mem_read, mem_write, reg_write, pc_src, reg_dst, mem_to_reg, halted} =
        reset_n ? {alu_op_d, alu_funct_d, alu_src_a_d, alu_src_b_d, ir_write_d,
                   pc_write_d, mem_read_d, mem_write_d, reg_write_d, pc_src_d,
                   reg_dst_d, mem_to_reg_d, halted_d}
                : CTRL_W'(0);

endmodule
